sos_coeff_loader: RTL and testbench

Runtime writer for the cascade SOS IIR coefficient bank. It accepts a stream of coefficient words over a valid/ready interface and fills a shadow bank. At the next sample boundary it commits the shadow bank atomically into the active bank that drives the SOS sections. The filter datapath therefore never sees a mix of old and new coefficients. It sits between the host/control interface and the SOS cascade, where the ROM-initialised coefficient registers would otherwise be.

---
 rtl/ae_iir_pkg.sv | 14 +
 rtl/sos_coeff_loader_if.sv | 25 ++
 rtl/sos_coeff_loader.sv | 212 +++++++++++++++++++++
 tb/tb_sos_coeff_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ae_iir_pkg.sv
// ae_iir_pkg: shared types for the cascade SOS IIR filter.
//   COF_WD                      - coefficient word width
//   TYDE_SOS_COEFF_DATA_COF_WD  - one second-order section's coefficients:
//                                 sos_coeff_b[2:0] (b0..b2), sos_coeff_a[2:1] (a1, a2)
package ae_iir_pkg;

   localparam int unsigned COF_WD = 16;

   typedef struct packed {
      logic [2:0][COF_WD-1:0] sos_coeff_b;
      logic [2:1][COF_WD-1:0] sos_coeff_a;
   } TYDE_SOS_COEFF_DATA_COF_WD;

endpackage

// File: rtl/sos_coeff_loader_if.sv
// sos_coeff_loader_if: valid/ready coefficient write stream into sos_coeff_loader.
//   valid - word on data is valid          (master -> slave)
//   data  - coefficient word, COF_WD bits  (master -> slave)
//   ready - loader accepts a word          (slave -> master)
interface sos_coeff_loader_if #(
   parameter int unsigned COF_WD = 16
) ();

   logic              valid;
   logic [COF_WD-1:0] data;
   logic              ready;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/sos_coeff_loader.sv
// sos_coeff_loader: runtime writer for the cascade SOS IIR coefficient bank.
//
// A load transaction streams 5*IIR_SOS_NUM coefficient words (per section: b0, b1, b2, a1, a2,
// sections in ascending order) into a shadow bank. Once the last word has been accepted the
// loader waits for the next sample-boundary strobe and copies the whole shadow bank into the
// active bank in one edge, so the filter never runs with a mix of old and new coefficients.
//
// Ports:
//   clk_i        - clock
//   rst_ni       - asynchronous active-low reset
//   start_i      - begin a load (only honoured when idle)
//   abort_i      - cancel the load/commit in progress; active bank untouched
//   sample_en_i  - sample-boundary strobe, commit point
//   wr           - coefficient write stream (sos_coeff_loader_if.slave)
//   busy_o       - load or commit pending
//   done_o       - one-cycle pulse when new coefficients appear on sos_o
//   sos_o        - active coefficient bank, sections IIR_SOS_NUM..1
//
// Optional readback (macro SOS_LOADER_READBACK_EN):
//   rd_sec_i     - section to read, 1..IIR_SOS_NUM
//   rd_slot_i    - slot to read: 0=b0 1=b1 2=b2 3=a1 4=a2
//   rd_data_o    - registered active-bank word, one cycle latency; 0 when out of range
module sos_coeff_loader #(
   parameter int unsigned COF_WD      = ae_iir_pkg::COF_WD,
   parameter int unsigned IIR_SOS_NUM = 4,
   localparam int unsigned SecW       = $clog2(IIR_SOS_NUM + 1)
) (
   input  logic                                                 clk_i,
   input  logic                                                 rst_ni,
   input  logic                                                 start_i,
   input  logic                                                 abort_i,
   input  logic                                                 sample_en_i,
   sos_coeff_loader_if.slave                                    wr,
   output logic                                                 busy_o,
   output logic                                                 done_o,
`ifdef SOS_LOADER_READBACK_EN
   input  logic [SecW-1:0]                                      rd_sec_i,
   input  logic [2:0]                                           rd_slot_i,
   output logic [COF_WD-1:0]                                    rd_data_o,
`endif
   output ae_iir_pkg::TYDE_SOS_COEFF_DATA_COF_WD [IIR_SOS_NUM:1] sos_o
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StPend = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [SecW-1:0] sec_q, sec_d;     // 0-based section being written
   logic [2:0]      slot_q, slot_d;   // 0..4 within the section
   logic            done_q, done_d;
   logic            accept;
   logic            last_word;
   logic            shadow_we;
   logic            commit;

   // Shadow bank indexed [section][slot], section 0-based.
   logic [IIR_SOS_NUM-1:0][4:0][COF_WD-1:0]                shadow_q, shadow_d;
   ae_iir_pkg::TYDE_SOS_COEFF_DATA_COF_WD [IIR_SOS_NUM:1] shadow_sos;
   ae_iir_pkg::TYDE_SOS_COEFF_DATA_COF_WD [IIR_SOS_NUM:1] sos_q, sos_d;

   // Handshake outputs come straight from registered state.
   assign wr.ready = (state_q == StLoad);
   assign busy_o   = (state_q != StIdle);
   assign done_o   = done_q;
   assign sos_o    = sos_q;

   assign accept    = wr.valid && wr.ready;
   assign last_word = (sec_q == SecW'(IIR_SOS_NUM - 1)) && (slot_q == 3'd4);

   // ---------------------------------------------------------------------------------------------
   // Control FSM and word counter
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      slot_d    = slot_q;
      shadow_we = 1'b0;
      commit    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StLoad;
               sec_d   = '0;
               slot_d  = '0;
            end
         end
         StLoad: begin
            // Abort wins over a word arriving in the same cycle; that word is dropped.
            if (abort_i) begin
               state_d = StIdle;
            end else if (accept) begin
               shadow_we = 1'b1;
               if (last_word) begin
                  state_d = StPend;
               end else if (slot_q == 3'd4) begin
                  slot_d = '0;
                  sec_d  = sec_q + 1'b1;
               end else begin
                  slot_d = slot_q + 3'd1;
               end
            end
         end
         StPend: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (sample_en_i) begin
               commit  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign done_d = commit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         sec_q   <= '0;
         slot_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         slot_q  <= slot_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Shadow bank: written one word at a time while loading; survives an abort
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      shadow_d = shadow_q;
      for (int s = 0; s < int'(IIR_SOS_NUM); s++) begin
         for (int k = 0; k < 5; k++) begin
            if (shadow_we && (sec_q == SecW'(s)) && (slot_q == 3'(k))) begin
               shadow_d[s][k] = wr.data;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Active bank: whole-bank copy on commit so every section updates on the same edge
   // ---------------------------------------------------------------------------------------------
   for (genvar g = 0; g < int'(IIR_SOS_NUM); g++) begin : g_pack
      assign shadow_sos[g+1].sos_coeff_b = {shadow_q[g][2], shadow_q[g][1], shadow_q[g][0]};
      assign shadow_sos[g+1].sos_coeff_a = {shadow_q[g][4], shadow_q[g][3]};
   end

   always_comb begin
      sos_d = sos_q;
      if (commit) begin
         sos_d = shadow_sos;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sos_q <= '0;
      end else begin
         sos_q <= sos_d;
      end
   end

`ifdef SOS_LOADER_READBACK_EN
   // ---------------------------------------------------------------------------------------------
   // Registered readback of the active bank; sections are 1-based, anything else reads 0
   // ---------------------------------------------------------------------------------------------
   logic [COF_WD-1:0] rd_data_q, rd_data_d;

   always_comb begin
      rd_data_d = '0;
      for (int s = 1; s <= int'(IIR_SOS_NUM); s++) begin
         if (rd_sec_i == SecW'(s)) begin
            case (rd_slot_i)
               3'd0:    rd_data_d = sos_q[s].sos_coeff_b[0];
               3'd1:    rd_data_d = sos_q[s].sos_coeff_b[1];
               3'd2:    rd_data_d = sos_q[s].sos_coeff_b[2];
               3'd3:    rd_data_d = sos_q[s].sos_coeff_a[1];
               3'd4:    rd_data_d = sos_q[s].sos_coeff_a[2];
               default: rd_data_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_sos_coeff_loader.sv
// tb_sos_coeff_loader: directed self-checking bench for sos_coeff_loader (IIR_SOS_NUM = 4).
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_sos_coeff_loader;

   localparam int unsigned N = 4;
   localparam int unsigned W = 16;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic start_i;
   logic abort_i;
   logic sample_en_i;
   logic busy_o;
   logic done_o;
   ae_iir_pkg::TYDE_SOS_COEFF_DATA_COF_WD [N:1] sos_o;
`ifdef SOS_LOADER_READBACK_EN
   logic [2:0]   rd_sec_i;
   logic [2:0]   rd_slot_i;
   logic [W-1:0] rd_data_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   sos_coeff_loader_if #(.COF_WD(W)) wr_if ();

   sos_coeff_loader #(
      .COF_WD      (W),
      .IIR_SOS_NUM (N)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .sample_en_i (sample_en_i),
      .wr          (wr_if),
      .busy_o      (busy_o),
      .done_o      (done_o),
`ifdef SOS_LOADER_READBACK_EN
      .rd_sec_i    (rd_sec_i),
      .rd_slot_i   (rd_slot_i),
      .rd_data_o   (rd_data_o),
`endif
      .sos_o       (sos_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [W-1:0] field(int s, int k);
      if (k < 3) return sos_o[s].sos_coeff_b[k];
      else if (k == 3) return sos_o[s].sos_coeff_a[1];
      else return sos_o[s].sos_coeff_a[2];
   endfunction

   // Expected word (s-1)*5 + k + base for section s, slot k.
   task automatic check_bank_seq(input string tag, input int base);
      for (int s = 1; s <= int'(N); s++)
         for (int k = 0; k < 5; k++)
            check($sformatf("%s[%0d][%0d]", tag, s, k), 32'(field(s, k)),
                  32'((s - 1) * 5 + k + base));
   endtask

   task automatic check_bank_const(input string tag, input logic [W-1:0] val);
      for (int s = 1; s <= int'(N); s++)
         for (int k = 0; k < 5; k++)
            check($sformatf("%s[%0d][%0d]", tag, s, k), 32'(field(s, k)), 32'(val));
   endtask

   task automatic start_load();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] d);
      wr_if.valid = 1'b1;
      wr_if.data  = d;
      step();
      wr_if.valid = 1'b0;
   endtask

   task automatic commit_and_check_done();
      sample_en_i = 1'b1;
      step();
      sample_en_i = 1'b0;
      check("done_pulse", 32'(done_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pat;
      int          sent;
      int          cyc;

      rst_ni      = 1'b0;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      sample_en_i = 1'b0;
      wr_if.valid = 1'b0;
      wr_if.data  = '0;
`ifdef SOS_LOADER_READBACK_EN
      rd_sec_i    = '0;
      rd_slot_i   = '0;
`endif
      #2;
      check("rst_ready", 32'(wr_if.ready), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check_bank_const("rst_bank", 16'h0000);
`ifdef SOS_LOADER_READBACK_EN
      check("rst_rd", 32'(rd_data_o), 32'd0);
`endif
      step();
      step();
      rst_ni = 1'b1;
      step();
      check("idle_ready", 32'(wr_if.ready), 32'd0);

      // Full-rate load of 0x0001..0x0014
      start_load();
      check("load_ready", 32'(wr_if.ready), 32'd1);
      check("load_busy", 32'(busy_o), 32'd1);
      for (int i = 0; i < 20; i++) send_word(W'(i + 1));
      check("pend_ready", 32'(wr_if.ready), 32'd0);
      check("pend_busy", 32'(busy_o), 32'd1);
      check("pend_done", 32'(done_o), 32'd0);
      check_bank_const("pend_bank", 16'h0000);
      commit_and_check_done();
      check_bank_seq("full_bank", 1);
      check("full_s1b0", 32'(sos_o[1].sos_coeff_b[0]), 32'h0001);
      check("full_s4a2", 32'(sos_o[4].sos_coeff_a[2]), 32'h0014);
      step();
      check("done_low", 32'(done_o), 32'd0);
      check("post_busy", 32'(busy_o), 32'd0);

`ifdef SOS_LOADER_READBACK_EN
      rd_sec_i  = 3'd3;
      rd_slot_i = 3'd3;
      step();
      check("rd_s3a1", 32'(rd_data_o), 32'h000E);
      rd_sec_i = 3'd5;
      step();
      check("rd_sec5", 32'(rd_data_o), 32'd0);
      rd_sec_i  = 3'd1;
      rd_slot_i = 3'd5;
      step();
      check("rd_slot5", 32'(rd_data_o), 32'd0);
      rd_slot_i = 3'd4;
      step();
      check("rd_s1a2", 32'(rd_data_o), 32'h0005);
`endif

      // Abort after 7 words: active bank keeps the previous commit
      start_load();
      for (int i = 0; i < 7; i++) send_word(16'hAAAA);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_ready", 32'(wr_if.ready), 32'd0);
      check_bank_seq("abort_bank", 1);

      // Full load of 0x5555
      start_load();
      for (int i = 0; i < 20; i++) send_word(16'h5555);
      commit_and_check_done();
      check_bank_const("c5555_bank", 16'h5555);
      step();

      // Gapped valid, sample_en pulsed during LOAD and with the last word
      start_load();
      pat  = 32'hB5D3_6E9A;
      sent = 0;
      cyc  = 0;
      while (sent < 20 && cyc < 200) begin
         wr_if.valid = pat[cyc % 32];
         wr_if.data  = W'(sent + 1);
         sample_en_i = (cyc % 3 == 0) || (pat[cyc % 32] && sent == 19);
         step();
         if (wr_if.valid) sent++;
         check("bp_done_low", 32'(done_o), 32'd0);
         check("bp_hold", 32'(sos_o[1].sos_coeff_b[0]), 32'h5555);
         cyc++;
      end
      wr_if.valid = 1'b0;
      sample_en_i = 1'b0;
      check("bp_words", 32'(sent), 32'd20);
      check("bp_pend_busy", 32'(busy_o), 32'd1);
      check("bp_pend_ready", 32'(wr_if.ready), 32'd0);
      step();
      check("bp_still_done0", 32'(done_o), 32'd0);
      check_bank_const("bp_hold_bank", 16'h5555);
      commit_and_check_done();
      check_bank_seq("bp_bank", 1);
      step();

      // start_i mid-load is ignored; 20 words still complete the load
      start_load();
      for (int i = 0; i < 3; i++) send_word(W'(16'h0201 + i));
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 3; i < 20; i++) send_word(W'(16'h0201 + i));
      check("ign_start_ready", 32'(wr_if.ready), 32'd0);
      check("ign_start_busy", 32'(busy_o), 32'd1);
      // abort with sample_en in PEND: no commit
      abort_i     = 1'b1;
      sample_en_i = 1'b1;
      step();
      abort_i     = 1'b0;
      sample_en_i = 1'b0;
      check("abt_se_done", 32'(done_o), 32'd0);
      check("abt_se_busy", 32'(busy_o), 32'd0);
      check_bank_seq("abt_se_bank", 1);

      // abort on the last word: word dropped, back to idle, later sample_en does nothing
      start_load();
      for (int i = 0; i < 19; i++) send_word(16'h0777);
      wr_if.valid = 1'b1;
      wr_if.data  = 16'h0777;
      abort_i     = 1'b1;
      step();
      wr_if.valid = 1'b0;
      abort_i     = 1'b0;
      check("abt_last_busy", 32'(busy_o), 32'd0);
      check("abt_last_ready", 32'(wr_if.ready), 32'd0);
      sample_en_i = 1'b1;
      step();
      sample_en_i = 1'b0;
      check("abt_last_done", 32'(done_o), 32'd0);
      check_bank_seq("abt_last_bank", 1);

      // Asynchronous reset in the middle of a load
      start_load();
      for (int i = 0; i < 5; i++) send_word(16'h0999);
      #2;
      rst_ni = 1'b0;
      #1;
      check("mid_rst_ready", 32'(wr_if.ready), 32'd0);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_done", 32'(done_o), 32'd0);
      check_bank_const("mid_rst_bank", 16'h0000);
      step();
      rst_ni = 1'b1;
      step();
      check("after_rst_busy", 32'(busy_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
